// File: rtl/word_mem_arbiter.sv
// Round-robin IF/DM sharing of a byte-wide memory; each 32-bit word is moved as 4 big-endian byte cycles.
// Latency: grant edge -> 4 byte cycles -> 1-cycle done pulse (6 cycles/word); requests are ignored while busy.
module word_mem_arbiter #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_done,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic [31:0]       dm_rdata,
  output logic              dm_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [23:0]       asm_q, asm_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       dm_rdata_q, dm_rdata_d;
  logic              if_done_q, if_done_d;
  logic              dm_done_q, dm_done_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;

  logic              grant_dm;
  logic [1:0]        nxt;
  logic [31:0]       shifted;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    last_d      = last_q;
    base_d      = base_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    asm_d       = asm_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_done_d   = 1'b0;
    dm_done_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    busy_d      = busy_q;
    grant_dm    = 1'b0;
    nxt         = cnt_q + 2'd1;
    shifted     = wdata_q << {nxt, 3'b000};

    case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          // On a tie the port that did not own the last transfer wins.
          grant_dm    = dm_req && (!if_req || last_q == OWN_IF);
          owner_d     = grant_dm;
          last_d      = grant_dm;
          base_d      = grant_dm ? dm_addr : if_addr;
          we_d        = grant_dm && dm_we;
          wdata_d     = grant_dm ? dm_wdata : 32'h0;
          cnt_d       = 2'd0;
          state_d     = XFER;
          busy_d      = 1'b1;
          mem_addr_d  = base_d;
          mem_we_d    = we_d;
          mem_wdata_d = we_d ? wdata_d[31:24] : 8'h00;
        end
      end
      XFER: begin
        asm_d = {asm_q[15:0], mem_rdata};
        if (cnt_q == 2'd3) begin
          state_d     = DONE;
          mem_addr_d  = '0;
          mem_we_d    = 1'b0;
          mem_wdata_d = 8'h00;
          if (owner_q == OWN_DM) dm_done_d = 1'b1;
          else                   if_done_d = 1'b1;
          if (!we_q) begin
            if (owner_q == OWN_DM) dm_rdata_d = {asm_q, mem_rdata};
            else                   if_rdata_d = {asm_q, mem_rdata};
          end
        end else begin
          cnt_d       = nxt;
          mem_addr_d  = base_q + ADDR_W'(nxt);
          mem_we_d    = we_q;
          mem_wdata_d = we_q ? shifted[31:24] : 8'h00;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      owner_q     <= OWN_IF;
      last_q      <= OWN_IF;
      base_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= 32'h0;
      asm_q       <= 24'h0;
      if_rdata_q  <= 32'h0;
      dm_rdata_q  <= 32'h0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 8'h00;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      base_q      <= base_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      asm_q       <= asm_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_done   = if_done_q;
  assign dm_done   = dm_done_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_word_mem_arbiter.sv
// Bench for word_mem_arbiter: byte memory model plus per-port scoreboards of expected read words.
module tb_word_mem_arbiter;

  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_rdata;
  logic              if_done;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_wdata;
  logic [31:0]       dm_rdata;
  logic              dm_done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              busy;

  word_mem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [32];
  logic       mem_init;

  function automatic logic [7:0] init_byte(input int i);
    case (i)
      4: return 8'h8C;
      5: return 8'h22;
      6: return 8'h00;
      7: return 8'h04;
      default: return 8'(8'h40 + i);
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_byte(i);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] if_exp[$];
  logic [31:0] dm_exp[$];
  logic [31:0] if_last, dm_last;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Completed transfers are matched against the per-port queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (if_done || dm_done) chk("done_excl", 64'(if_done & dm_done), 64'd0);
      if (if_done) begin
        if (if_exp.size() == 0) chk("if_unexpected_done", 64'd1, 64'd0);
        else chk("if_rdata", 64'(if_rdata), 64'(if_exp.pop_front()));
      end
      if (dm_done) begin
        if (dm_exp.size() == 0) chk("dm_unexpected_done", 64'd1, 64'd0);
        else chk("dm_rdata", 64'(dm_rdata), 64'(dm_exp.pop_front()));
      end
    end
  end

  task automatic next_cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk(tag, {if_done, dm_done, mem_we, busy, 3'b0, mem_addr, mem_wdata},
        64'd0);
    chk({tag, "_rdata"}, {if_rdata, dm_rdata}, 64'd0);
  endtask

  // One isolated transfer, called at a post-edge point with the arbiter idle.
  task automatic run_word(input bit is_dm, input bit we, input logic [4:0] a,
                          input logic [31:0] wd, input logic [31:0] rexp);
    logic [4:0]  ea;
    logic [31:0] sh;
    if (is_dm) begin
      dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = wd;
      if (!we) dm_last = rexp;
      dm_exp.push_back(dm_last);
    end else begin
      if_req = 1'b1; if_addr = a;
      if_last = rexp;
      if_exp.push_back(if_last);
    end
    for (int k = 0; k < 4; k++) begin
      next_cyc();
      ea = a + 5'(k);
      sh = wd << (8 * k);
      chk($sformatf("mem_addr_b%0d", k), 64'(mem_addr), 64'(ea));
      chk($sformatf("mem_we_b%0d", k), 64'(mem_we), 64'(we));
      chk($sformatf("mem_wdata_b%0d", k), 64'(mem_wdata), we ? 64'(sh[31:24]) : 64'd0);
      chk($sformatf("busy_b%0d", k), 64'(busy), 64'd1);
    end
    next_cyc();
    chk("done_own", 64'(is_dm ? dm_done : if_done), 64'd1);
    chk("done_other", 64'(is_dm ? if_done : dm_done), 64'd0);
    chk("mem_we_done", 64'(mem_we), 64'd0);
    if (is_dm) dm_req = 1'b0; else if_req = 1'b0;
    next_cyc();
    chk("busy_idle", 64'(busy), 64'd0);
  endtask

  // Both ports start requesting at cycle 0; records the first two done cycles per port.
  task automatic race(input int ncyc, input int dm_drop, input int if_drop,
                      output int dm_t[2], output int if_t[2],
                      output int dm_n, output int if_n);
    dm_n = 0; if_n = 0;
    dm_t[0] = -1; dm_t[1] = -1; if_t[0] = -1; if_t[1] = -1;
    for (int c = 1; c <= ncyc; c++) begin
      next_cyc();
      if (dm_done) begin if (dm_n < 2) dm_t[dm_n] = c; dm_n++; end
      if (if_done) begin if (if_n < 2) if_t[if_n] = c; if_n++; end
      if (c == dm_drop) dm_req = 1'b0;
      if (c == if_drop) if_req = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dm_t[2];
    int if_t[2];
    int dm_n, if_n;
    logic [7:0] old2, old3;

    rst_n = 1'b0; mem_init = 1'b1;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = 32'h0;
    if_last = 32'h0; dm_last = 32'h0;
    repeat (3) next_cyc();
    mem_init = 1'b0;
    chk_reset_outs("reset");
    rst_n = 1'b1;
    next_cyc();

    // IF read of bytes 4..7.
    run_word(1'b0, 1'b0, 5'd4, 32'h0, 32'h8C220004);

    // DM write then read back; IF word must stay put.
    run_word(1'b1, 1'b1, 5'd8, 32'hDEADBEEF, 32'h0);
    chk("mem8_11", {32'h0, mem[8], mem[9], mem[10], mem[11]}, 64'hDEADBEEF);
    run_word(1'b1, 1'b0, 5'd8, 32'h0, 32'hDEADBEEF);
    chk("if_rdata_held", 64'(if_rdata), 64'h8C220004);

    // Fresh reset, then simultaneous requests: DM wins the first tie.
    rst_n = 1'b0;
    #1;
    chk_reset_outs("reset2");
    if_last = 32'h0; dm_last = 32'h0;
    next_cyc();
    rst_n = 1'b1;
    next_cyc();
    if_req = 1'b1; if_addr = 5'd4;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 5'd8;
    dm_exp.push_back(32'hDEADBEEF);
    if_exp.push_back(32'h8C220004);
    race(11, 5, 11, dm_t, if_t, dm_n, if_n);
    chk("tie_dm_cycle", 64'(dm_t[0]), 64'd5);
    chk("tie_if_cycle", 64'(if_t[0]), 64'd11);
    chk("tie_counts", {32'(dm_n), 32'(if_n)}, {32'd1, 32'd1});
    next_cyc();
    chk("tie_idle", 64'(busy), 64'd0);

    // Both held continuously: grants alternate, each port every 12 cycles.
    if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0;
    repeat (2) begin
      dm_exp.push_back(32'hDEADBEEF);
      if_exp.push_back(32'h8C220004);
    end
    race(23, 23, 23, dm_t, if_t, dm_n, if_n);
    chk("rr_dm_t0", 64'(dm_t[0]), 64'd5);
    chk("rr_if_t0", 64'(if_t[0]), 64'd11);
    chk("rr_dm_t1", 64'(dm_t[1]), 64'd17);
    chk("rr_if_t1", 64'(if_t[1]), 64'd23);
    chk("rr_counts", {32'(dm_n), 32'(if_n)}, {32'd2, 32'd2});
    next_cyc();
    chk("rr_idle", 64'(busy), 64'd0);
    dm_last = 32'hDEADBEEF; if_last = 32'h8C220004;

    // Address wrap at the top of memory.
    run_word(1'b1, 1'b1, 5'd30, 32'h11223344, 32'h0);
    chk("wrap_mem", {32'h0, mem[30], mem[31], mem[0], mem[1]}, 64'h11223344);
    run_word(1'b1, 1'b0, 5'd30, 32'h0, 32'h11223344);

    // Reset in the third byte cycle of a write: partial write, no done.
    old2 = mem[2]; old3 = mem[3];
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 5'd0; dm_wdata = 32'hAABBCCDD;
    repeat (3) next_cyc();
    chk("pre_abort_addr", 64'(mem_addr), 64'd2);
    rst_n = 1'b0; dm_req = 1'b0;
    #1;
    chk_reset_outs("abort");
    for (int c = 0; c < 3; c++) begin
      next_cyc();
      chk("abort_no_done", {62'd0, if_done, dm_done}, 64'd0);
    end
    chk("abort_mem", {32'h0, mem[0], mem[1], mem[2], mem[3]},
        {32'h0, 8'hAA, 8'hBB, old2, old3});
    rst_n = 1'b1;
    repeat (3) next_cyc();
    chk("abort_idle", 64'(busy), 64'd0);

    chk("if_queue_empty", 64'(if_exp.size()), 64'd0);
    chk("dm_queue_empty", 64'(dm_exp.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
